snake_engine: RTL and testbench

// Parametrised snake game engine: direction FSM, circular-buffer body store,

---
 rtl/snake_engine.sv | 276 +++++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// Snake game engine: stepping FSM over a circular body buffer that emits only the
// changed pixels (tail erase, head draw) on a valid/ready stream towards the plotter.
module snake_engine #(
  parameter int MAX_LEN  = 64,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int INIT_LEN = 4,
  parameter int GROW     = 4,
  parameter int TICK_DIV = 6666666
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           btn_up,
  input  logic           btn_dn,
  input  logic           btn_lf,
  input  logic           btn_rt,
  input  logic           pause,
  input  logic [X_W-1:0] food_x,
  input  logic [Y_W-1:0] food_y,
  output logic           food_eaten,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [2:0]     pix_colour,
  output logic [8:0]     length,
  output logic [7:0]     score,
  output logic [7:0]     highscore,
  output logic           dead
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] X0   = X_W'(GRID_W / 2);
  localparam logic [X_W-1:0] XMAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y0   = Y_W'(GRID_H / 2);
  localparam logic [Y_W-1:0] YMAX = Y_W'(GRID_H - 1);
  localparam logic [8:0] LEN0   = 9'(INIT_LEN);
  localparam logic [8:0] LENMAX = 9'(MAX_LEN);
  localparam logic [8:0] GROW9  = 9'(GROW);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CHECK, S_ERASE, S_DRAW, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP, D_DN, D_LF, D_RT} dir_t;

  state_t         state_q, state_d;
  dir_t           dir_q, dir_d, ndir_q, ndir_d;
  logic [PW-1:0]  head_q, head_d;
  logic [8:0]     cnt_q, cnt_d, len_q, len_d, grow_q, grow_d;
  logic [7:0]     score_q, score_d, hs_q, hs_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic           pend_q, pend_d;
  logic [X_W-1:0] nhx_q, nhx_d, px_q, px_d;
  logic [Y_W-1:0] nhy_q, nhy_d, py_q, py_d;
  logic [2:0]     pc_q, pc_d;
  logic           pv_q, pv_d, eat_q, eat_d;

  logic [X_W-1:0] body_x [MAX_LEN];
  logic [Y_W-1:0] body_y [MAX_LEN];
  logic           wr_en;
  logic [PW-1:0]  wr_idx;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;

  logic           tick, wall, advance;
  logic [PW-1:0]  rd_idx, tail_idx;
  logic [8:0]     last_idx;

  // Segment i lives at head-i; the tail is derived from length, so no tail pointer.
  assign rd_idx   = head_q - cnt_q[PW-1:0];
  assign tail_idx = head_q - PW'(len_q - 9'd1);
  assign tick     = !pause && (tick_q == TICK_LAST);
  assign wall     = (nhx_q == '0) || (nhx_q == XMAX) || (nhy_q == '0) || (nhy_q == YMAX);
  assign last_idx = (grow_q != '0) ? len_q - 9'd1 : len_q - 9'd2;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ndir_d  = ndir_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    grow_d  = grow_q;
    score_d = score_q;
    hs_d    = (score_q > hs_q) ? score_q : hs_q;
    pend_d  = pend_q;
    nhx_d   = nhx_q;
    nhy_d   = nhy_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    pv_d    = pv_q;
    eat_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = head_q + 1'b1;
    wr_x    = nhx_q;
    wr_y    = nhy_q;
    advance = 1'b0;

    tick_d = pause ? tick_q : (tick ? '0 : tick_q + 1'b1);
    if (tick && (state_q != S_IDLE)) pend_d = 1'b1;

    if (btn_up && (dir_q != D_DN))      ndir_d = D_UP;
    else if (btn_dn && (dir_q != D_UP)) ndir_d = D_DN;
    else if (btn_lf && (dir_q != D_RT)) ndir_d = D_LF;
    else if (btn_rt && (dir_q != D_LF)) ndir_d = D_RT;

    unique case (state_q)
      S_INIT: begin
        if (!pv_q || pix_ready) begin
          if (cnt_q < LEN0) begin
            wr_en  = 1'b1;
            wr_idx = rd_idx;
            wr_x   = X0 - X_W'(cnt_q);
            wr_y   = Y0;
            pv_d   = 1'b1;
            px_d   = X0 - X_W'(cnt_q);
            py_d   = Y0;
            pc_d   = 3'b111;
            cnt_d  = cnt_q + 9'd1;
          end else begin
            pv_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if ((tick || pend_q) && !pause) begin
          pend_d  = 1'b0;
          dir_d   = ndir_q;
          nhx_d   = body_x[head_q];
          nhy_d   = body_y[head_q];
          case (ndir_q)
            D_UP:    nhy_d = body_y[head_q] - 1'b1;
            D_DN:    nhy_d = body_y[head_q] + 1'b1;
            D_LF:    nhx_d = body_x[head_q] - 1'b1;
            default: nhx_d = body_x[head_q] + 1'b1;
          endcase
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (wall || ((body_x[rd_idx] == nhx_q) && (body_y[rd_idx] == nhy_q))) begin
          cnt_d   = '0;
          state_d = S_DEAD;
        end else if (cnt_q == last_idx) begin
          state_d = S_ERASE;
          if (grow_q == '0) begin
            pv_d = 1'b1;
            px_d = body_x[tail_idx];
            py_d = body_y[tail_idx];
            pc_d = 3'b000;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_ERASE: begin
        // Growing steps skip the tail erase; the head write then never lands on the tail.
        if (grow_q != '0) begin
          advance = 1'b1;
          len_d   = len_q + 9'd1;
          grow_d  = ((len_q + 9'd1) == LENMAX) ? '0 : grow_q - 9'd1;
        end else if (pix_ready) begin
          advance = 1'b1;
        end
        if (advance) begin
          wr_en   = 1'b1;
          head_d  = head_q + 1'b1;
          pv_d    = 1'b1;
          px_d    = nhx_q;
          py_d    = nhy_q;
          pc_d    = 3'b111;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (pix_ready) begin
          pv_d    = 1'b0;
          state_d = S_IDLE;
          if ((nhx_q == food_x) && (nhy_q == food_y)) begin
            eat_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            if (len_q < LENMAX) grow_d = grow_q + GROW9;
          end
        end
      end
      S_DEAD: begin
        if (!pv_q || pix_ready) begin
          if (cnt_q < len_q) begin
            pv_d  = 1'b1;
            px_d  = body_x[rd_idx];
            py_d  = body_y[rd_idx];
            pc_d  = 3'b000;
            cnt_d = cnt_q + 9'd1;
          end else begin
            pv_d    = 1'b0;
            score_d = '0;
            len_d   = LEN0;
            grow_d  = '0;
            dir_d   = D_RT;
            ndir_d  = D_RT;
            head_d  = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = S_INIT;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_INIT;
      dir_q   <= D_RT;
      ndir_q  <= D_RT;
      head_q  <= '0;
      cnt_q   <= '0;
      len_q   <= LEN0;
      grow_q  <= '0;
      score_q <= '0;
      hs_q    <= '0;
      tick_q  <= '0;
      pend_q  <= 1'b0;
      nhx_q   <= '0;
      nhy_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      pv_q    <= 1'b0;
      eat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ndir_q  <= ndir_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      grow_q  <= grow_d;
      score_q <= score_d;
      hs_q    <= hs_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      nhx_q   <= nhx_d;
      nhy_q   <= nhy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      pv_q    <= pv_d;
      eat_q   <= eat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      body_x[wr_idx] <= wr_x;
      body_y[wr_idx] <= wr_y;
    end
  end

  assign food_eaten = eat_q;
  assign pix_valid  = pv_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign pix_colour = pc_q;
  assign length     = len_q;
  assign score      = score_q;
  assign highscore  = hs_q;
  assign dead       = (state_q == S_DEAD);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a small body model predicts each erase/draw pixel.
module tb_snake_engine;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_up = 1'b0, btn_dn = 1'b0, btn_lf = 1'b0, btn_rt = 1'b0, pause = 1'b0;
  logic [7:0] food_x = 8'd10;
  logic [6:0] food_y = 7'd10;
  logic       food_eaten, pix_valid, pix_ready = 1'b1, dead;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic [8:0] length;
  logic [7:0] score, highscore;

  int checks = 0;
  int errors = 0;
  int qx[$], qy[$], qc[$];
  int eat_cnt = 0;
  int bx[$], by[$];
  int grow_m = 0;

  snake_engine #(.MAX_LEN(64), .X_W(8), .Y_W(7), .GRID_W(160), .GRID_H(120),
                 .INIT_LEN(4), .GROW(4), .TICK_DIV(32)) dut (
    .clk(clk), .resetn(resetn), .btn_up(btn_up), .btn_dn(btn_dn), .btn_lf(btn_lf),
    .btn_rt(btn_rt), .pause(pause), .food_x(food_x), .food_y(food_y),
    .food_eaten(food_eaten), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .length(length),
    .score(score), .highscore(highscore), .dead(dead)
  );

  always #5 clk = ~clk;

  // A transfer seen at the falling edge completes on the following rising edge.
  always @(negedge clk) begin
    if (resetn && pix_valid && pix_ready) begin
      qx.push_back(int'(pix_x));
      qy.push_back(int'(pix_y));
      qc.push_back(int'(pix_colour));
    end
    if (resetn && food_eaten) eat_cnt++;
  end

  task automatic get_pix(input int budget, output int x, output int y, output int c, output bit ok);
    int n = 0;
    ok = 1'b0; x = -1; y = -1; c = -1;
    while (qx.size() == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (qx.size() > 0) begin
      x = qx.pop_front(); y = qy.pop_front(); c = qc.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic model_init();
    bx.delete(); by.delete();
    for (int i = 0; i < 4; i++) begin
      bx.push_back(80 - i);
      by.push_back(60);
    end
    grow_m = 0;
  endtask

  task automatic model_step(input int d, output bit er, output int ex, output int ey,
                            output int hx, output int hy);
    int tmp;
    hx = bx[0]; hy = by[0];
    case (d)
      0: hy = hy - 1;
      1: hy = hy + 1;
      2: hx = hx - 1;
      default: hx = hx + 1;
    endcase
    er = 1'b0; ex = -1; ey = -1;
    if (grow_m == 0) begin
      er = 1'b1;
      ex = bx[$]; ey = by[$];
      tmp = bx.pop_back();
      tmp = by.pop_back();
    end else begin
      grow_m--;
    end
    bx.push_front(hx);
    by.push_front(hy);
    if (hx == int'(food_x) && hy == int'(food_y)) grow_m += 4;
  endtask

  task automatic pulse_btn(input int which);
    @(posedge clk); #1;
    case (which)
      0: btn_up = 1'b1;
      1: btn_dn = 1'b1;
      2: btn_lf = 1'b1;
      default: btn_rt = 1'b1;
    endcase
    @(posedge clk); #1;
    btn_up = 1'b0; btn_dn = 1'b0; btn_lf = 1'b0; btn_rt = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_x !== 8'd0 || pix_y !== 7'd0 || pix_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_pix: got v=%b x=%0d y=%0d c=%0d, expected all 0", pix_valid, pix_x, pix_y, pix_colour);
    end
    checks++;
    if (score !== 8'd0 || highscore !== 8'd0 || food_eaten !== 1'b0) begin
      errors++;
      $display("FAIL reset_score: got score=%0d hs=%0d eat=%b, expected 0 0 0", score, highscore, food_eaten);
    end
    checks++;
    if (length !== 9'd4 || dead !== 1'b0) begin
      errors++;
      $display("FAIL reset_len: got length=%0d dead=%b, expected 4 0", length, dead);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_init(input string tag);
    int x, y, c;
    bit ok;
    model_init();
    for (int i = 0; i < 4; i++) begin
      get_pix(60, x, y, c, ok);
      checks++;
      if (!ok || x !== 80 - i || y !== 60 || c !== 7) begin
        errors++;
        $display("FAIL %s_pix%0d: got ok=%b (%0d,%0d) c=%0d, expected (%0d,60) c=7", tag, i, ok, x, y, c, 80 - i);
      end
    end
  endtask

  task automatic test_idle_after_init();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (qx.size() != 0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL init_idle: got %0d extra pixels, valid=%b, expected 0 and 0", qx.size(), pix_valid);
    end
  endtask

  task automatic test_step();
    int x, y, c, ex, ey, hx, hy;
    bit ok, er;
    model_step(3, er, ex, ey, hx, hy);
    get_pix(100, x, y, c, ok);
    checks++;
    if (!ok || x !== 77 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL step_erase: got ok=%b (%0d,%0d) c=%0d, expected (77,60) c=0", ok, x, y, c);
    end
    get_pix(20, x, y, c, ok);
    checks++;
    if (!ok || x !== 81 || y !== 60 || c !== 7) begin
      errors++;
      $display("FAIL step_draw: got ok=%b (%0d,%0d) c=%0d, expected (81,60) c=7", ok, x, y, c);
    end
    checks++;
    if (length !== 9'd4) begin
      errors++;
      $display("FAIL step_len: got %0d, expected 4", length);
    end
  endtask

  task automatic test_direction();
    int x, y, c, ex, ey, hx, hy;
    bit ok, er;
    pulse_btn(2);
    model_step(3, er, ex, ey, hx, hy);
    get_pix(100, x, y, c, ok);
    checks++;
    if (!ok || x !== 78 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL rev_erase: got ok=%b (%0d,%0d) c=%0d, expected (78,60) c=0", ok, x, y, c);
    end
    get_pix(20, x, y, c, ok);
    checks++;
    if (!ok || x !== 82 || y !== 60 || c !== 7) begin
      errors++;
      $display("FAIL rev_ignored: got ok=%b (%0d,%0d) c=%0d, expected (82,60) c=7", ok, x, y, c);
    end
    pulse_btn(0);
    model_step(0, er, ex, ey, hx, hy);
    get_pix(100, x, y, c, ok);
    checks++;
    if (!ok || x !== 79 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL up_erase: got ok=%b (%0d,%0d) c=%0d, expected (79,60) c=0", ok, x, y, c);
    end
    get_pix(20, x, y, c, ok);
    checks++;
    if (!ok || x !== 82 || y !== 59 || c !== 7) begin
      errors++;
      $display("FAIL up_draw: got ok=%b (%0d,%0d) c=%0d, expected (82,59) c=7", ok, x, y, c);
    end
  endtask

  task automatic test_food();
    int x, y, c, ex, ey, hx, hy, e0;
    bit ok, er;
    @(posedge clk); #1;
    food_x = 8'd82; food_y = 7'd58;
    e0 = eat_cnt;
    model_step(0, er, ex, ey, hx, hy);
    get_pix(100, x, y, c, ok);
    checks++;
    if (!ok || x !== 80 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL food_erase: got ok=%b (%0d,%0d) c=%0d, expected (80,60) c=0", ok, x, y, c);
    end
    get_pix(20, x, y, c, ok);
    checks++;
    if (!ok || x !== 82 || y !== 58 || c !== 7) begin
      errors++;
      $display("FAIL food_draw: got ok=%b (%0d,%0d) c=%0d, expected (82,58) c=7", ok, x, y, c);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (eat_cnt !== e0 + 1 || score !== 8'd1) begin
      errors++;
      $display("FAIL food_pulse: got pulses=%0d score=%0d, expected 1 and 1", eat_cnt - e0, score);
    end
    @(posedge clk); #1;
    food_x = 8'd10; food_y = 7'd10;
    for (int s = 0; s < 4; s++) begin
      model_step(0, er, ex, ey, hx, hy);
      get_pix(100, x, y, c, ok);
      checks++;
      if (!ok || er || x !== hx || y !== hy || c !== 7) begin
        errors++;
        $display("FAIL grow_step%0d: got ok=%b (%0d,%0d) c=%0d, expected (%0d,%0d) c=7 no erase", s, ok, x, y, c, hx, hy);
      end
    end
    checks++;
    if (length !== 9'd8 || highscore !== 8'd1) begin
      errors++;
      $display("FAIL grow_len: got length=%0d hs=%0d, expected 8 1", length, highscore);
    end
  endtask

  task automatic test_wall();
    int x, y, c, ex, ey, hx, hy;
    bit ok, er;
    pulse_btn(3);
    while (bx[0] + 1 < 159) begin
      model_step(3, er, ex, ey, hx, hy);
      get_pix(100, x, y, c, ok);
      checks++;
      if (!ok || x !== ex || y !== ey || c !== 0) begin
        errors++;
        $display("FAIL walk_erase: got ok=%b (%0d,%0d) c=%0d, expected (%0d,%0d) c=0", ok, x, y, c, ex, ey);
      end
      get_pix(20, x, y, c, ok);
      checks++;
      if (!ok || x !== hx || y !== hy || c !== 7) begin
        errors++;
        $display("FAIL walk_draw: got ok=%b (%0d,%0d) c=%0d, expected (%0d,%0d) c=7", ok, x, y, c, hx, hy);
      end
    end
    for (int i = 0; i < 8; i++) begin
      get_pix((i == 0) ? 100 : 20, x, y, c, ok);
      checks++;
      if (!ok || x !== bx[i] || y !== by[i] || c !== 0) begin
        errors++;
        $display("FAIL death_erase%0d: got ok=%b (%0d,%0d) c=%0d, expected (%0d,%0d) c=0", i, ok, x, y, c, bx[i], by[i]);
      end
      if (i == 0) begin
        checks++;
        if (dead !== 1'b1) begin
          errors++;
          $display("FAIL death_flag: got %b, expected 1", dead);
        end
      end
    end
    test_init("respawn");
    checks++;
    if (score !== 8'd0 || highscore !== 8'd1 || length !== 9'd4 || dead !== 1'b0) begin
      errors++;
      $display("FAIL respawn_state: got score=%0d hs=%0d len=%0d dead=%b, expected 0 1 4 0", score, highscore, length, dead);
    end
  endtask

  task automatic test_backpressure();
    int x, y, c, ex, ey, hx, hy;
    bit ok, er;
    model_step(3, er, ex, ey, hx, hy);
    get_pix(100, x, y, c, ok);
    checks++;
    if (!ok || x !== 77 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL bp_erase: got ok=%b (%0d,%0d) c=%0d, expected (77,60) c=0", ok, x, y, c);
    end
    @(posedge clk); #1;
    pix_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b1 || pix_x !== 8'd81 || pix_y !== 7'd60 || pix_colour !== 3'd7) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b (%0d,%0d) c=%0d, expected v=1 (81,60) c=7", i, pix_valid, pix_x, pix_y, pix_colour);
      end
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    get_pix(5, x, y, c, ok);
    checks++;
    if (!ok || x !== 81 || y !== 60 || c !== 7) begin
      errors++;
      $display("FAIL bp_draw: got ok=%b (%0d,%0d) c=%0d, expected (81,60) c=7", ok, x, y, c);
    end
    // The stall spanned a tick, so the following step must start straight away.
    model_step(3, er, ex, ey, hx, hy);
    get_pix(12, x, y, c, ok);
    checks++;
    if (!ok || x !== 78 || y !== 60 || c !== 0) begin
      errors++;
      $display("FAIL bp_pending_erase: got ok=%b (%0d,%0d) c=%0d, expected (78,60) c=0", ok, x, y, c);
    end
    get_pix(20, x, y, c, ok);
    checks++;
    if (!ok || x !== 82 || y !== 60 || c !== 7) begin
      errors++;
      $display("FAIL bp_pending_draw: got ok=%b (%0d,%0d) c=%0d, expected (82,60) c=7", ok, x, y, c);
    end
  endtask

  task automatic test_reset_midtransfer();
    int n = 0;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    while (pix_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_wait: got valid=%b after %0d cycles, expected 1", pix_valid, n);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || length !== 9'd4 || score !== 8'd0 || highscore !== 8'd0) begin
      errors++;
      $display("FAIL midrst_drop: got v=%b len=%0d score=%0d hs=%0d, expected 0 4 0 0", pix_valid, length, score, highscore);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    pix_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_idle_after_init();
    test_step();
    test_direction();
    test_food();
    test_wall();
    test_backpressure();
    test_reset_midtransfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
